// File: rtl/delay_unit_dispatcher.sv
// delay_unit_dispatcher
// Shares a pool of variable-latency units among one in-order stream. Items are
// dispatched round-robin, each unit holds one item until its result has been
// drained, and results leave in acceptance order through per-unit result slots.
module delay_unit_dispatcher #(
    parameter int width   = 16,
    parameter int n_units = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_vld,
    input  logic [width-1:0]           up_data,
    output logic                       up_rdy,
    output logic [n_units-1:0]         unit_vld,
    output logic [width-1:0]           unit_data,
    input  logic [n_units-1:0]         unit_done_vld,
    input  logic [n_units*width-1:0]   unit_done_data,
    output logic                       down_vld,
    output logic [width-1:0]           down_data,
    output logic                       err
);

    localparam int PW = (n_units > 1) ? $clog2(n_units) : 1;

    typedef logic [PW-1:0] ptr_t;

    // Round-robin successor; n_units need not be a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(n_units - 1)) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

    ptr_t               wr_ptr_q, wr_ptr_d;
    ptr_t               rd_ptr_q, rd_ptr_d;
    logic [n_units-1:0] busy_q, busy_d;
    logic [n_units-1:0] slot_full_q, slot_full_d;
    logic [width-1:0]   slot_q [n_units];
    logic [width-1:0]   slot_d [n_units];
    logic [n_units-1:0] unit_vld_q, unit_vld_d;
    logic [width-1:0]   unit_data_q, unit_data_d;
    logic               down_vld_q, down_vld_d;
    logic [width-1:0]   down_data_q, down_data_d;
    logic               err_q, err_d;

    // Readiness depends only on registered occupancy, never on up_vld.
    assign up_rdy    = !busy_q[wr_ptr_q];
    assign unit_vld  = unit_vld_q;
    assign unit_data = unit_data_q;
    assign down_vld  = down_vld_q;
    assign down_data = down_data_q;
    assign err       = err_q;

    // Next state: dispatch to wr_ptr unit, capture completions, drain rd_ptr slot.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        busy_d      = busy_q;
        slot_full_d = slot_full_q;
        slot_d      = slot_q;
        unit_vld_d  = '0;
        unit_data_d = unit_data_q;
        down_vld_d  = 1'b0;
        down_data_d = down_data_q;
        err_d       = err_q;

        if (up_vld && !busy_q[wr_ptr_q]) begin
            busy_d[wr_ptr_q]     = 1'b1;
            unit_vld_d[wr_ptr_q] = 1'b1;
            unit_data_d          = up_data;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end

        // A completion is legal only for an occupied unit whose slot is empty.
        for (int i = 0; i < n_units; i++) begin
            if (unit_done_vld[i]) begin
                if (busy_q[i] && !slot_full_q[i]) begin
                    slot_d[i]      = unit_done_data[i*width +: width];
                    slot_full_d[i] = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        // Drain looks at registered slot state, so it never collides with a
        // capture on the same unit (that capture would be an error instead).
        if (slot_full_q[rd_ptr_q]) begin
            down_vld_d            = 1'b1;
            down_data_d           = slot_q[rd_ptr_q];
            slot_full_d[rd_ptr_q] = 1'b0;
            busy_d[rd_ptr_q]      = 1'b0;
            rd_ptr_d              = ptr_inc(rd_ptr_q);
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            busy_q      <= '0;
            slot_full_q <= '0;
            unit_vld_q  <= '0;
            unit_data_q <= '0;
            down_vld_q  <= 1'b0;
            down_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            busy_q      <= busy_d;
            slot_full_q <= slot_full_d;
            unit_vld_q  <= unit_vld_d;
            unit_data_q <= unit_data_d;
            down_vld_q  <= down_vld_d;
            down_data_q <= down_data_d;
            err_q       <= err_d;
        end
    end

    // Result slot storage.
    always_ff @(posedge clk) begin
        // NOTE: slot contents are not reset; slot_full qualifies them, so reset only costs logic here.
        slot_q <= slot_d;
    end

endmodule

// File: tb/tb_delay_unit_dispatcher.sv
// tb_delay_unit_dispatcher
// Randomized and directed stimulus with behavioural unit models; expected
// results are queued at acceptance and checked by an independent monitor.
module tb_delay_unit_dispatcher;

    localparam int W = 16;
    localparam int N = 5;

    typedef struct {
        int           unit;
        logic [W-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             up_vld = 1'b0;
    logic [W-1:0]     up_data = '0;
    logic             up_rdy;
    logic [N-1:0]     unit_vld;
    logic [W-1:0]     unit_data;
    logic [N-1:0]     unit_done_vld;
    logic [N*W-1:0]   unit_done_data;
    logic             down_vld;
    logic [W-1:0]     down_data;
    logic             err;

    // Unit models
    logic [N-1:0]     done_v = '0;
    logic [N-1:0]     inj = '0;
    logic [N*W-1:0]   done_d = '0;
    int               cnt [N];
    logic [W-1:0]     held [N];
    int               dly [N];
    bit               rand_dly = 1'b0;

    // Reference model
    exp_t             sb [$];
    bit               occ [N];
    int               m_wr = 0;
    logic [N-1:0]     exp_strobe = '0;
    logic [W-1:0]     exp_udata = '0;
    logic             exp_err = 1'b0;

    int               n_vec = 0;
    int               n_bad = 0;
    int               cyc = 0;
    int               ph_cnt = 0;
    int               ph_first = 0;
    int               ph_last = 0;

    assign unit_done_vld = done_v | inj;
    assign unit_done_data = done_d;

    delay_unit_dispatcher #(.width(W), .n_units(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .up_vld         (up_vld),
        .up_data        (up_data),
        .up_rdy         (up_rdy),
        .unit_vld       (unit_vld),
        .unit_data      (unit_data),
        .unit_done_vld  (unit_done_vld),
        .unit_done_data (unit_done_data),
        .down_vld       (down_vld),
        .down_data      (down_data),
        .err            (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each unit: latch the item on its strobe, return it unchanged after its delay.
    initial for (int i = 0; i < N; i++) begin
        cnt[i] = 0;
        held[i] = '0;
        dly[i] = 1;
        occ[i] = 1'b0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            done_v[i] <= 1'b0;
            if (rst) begin
                cnt[i] <= 0;
            end else if (unit_vld[i]) begin
                cnt[i]  <= rand_dly ? int'($urandom_range(1, N)) : dly[i];
                held[i] <= unit_data;
            end else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] - 1;
                if (cnt[i] == 1) begin
                    done_v[i]          <= 1'b1;
                    done_d[i*W +: W]   <= held[i];
                end
            end
        end
    end

    // Monitor: every output pulse must match the oldest accepted item.
    always @(negedge clk) begin
        if (down_vld === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_down_vld", 32'(down_data), 32'hDEAD_0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("down_data", 32'(down_data), 32'(e.data));
                occ[e.unit] = 1'b0;
            end
            if (ph_cnt == 0) ph_first = cyc;
            ph_last = cyc;
            ph_cnt++;
        end
    end

    // One stimulus cycle: check strobe/ready/err against the model, then drive.
    task automatic drive_cycle(input bit v, input logic [W-1:0] d, output bit acc);
        bit exp_rdy;
        @(negedge clk);
        #1;
        check("unit_vld", 32'(unit_vld), 32'(exp_strobe));
        if (exp_strobe != 0) check("unit_data", 32'(unit_data), 32'(exp_udata));
        exp_rdy = !occ[m_wr];
        check("up_rdy", 32'(up_rdy), 32'(exp_rdy));
        check("err", 32'(err), 32'(exp_err));
        up_vld  = v;
        up_data = d;
        acc = v && exp_rdy;
        exp_strobe = '0;
        if (acc) begin
            exp_t e;
            e.unit = m_wr;
            e.data = d;
            sb.push_back(e);
            occ[m_wr] = 1'b1;
            exp_strobe[m_wr] = 1'b1;
            exp_udata = d;
            m_wr = (m_wr + 1) % N;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, acc);
    endtask

    task automatic push(input logic [W-1:0] d);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            drive_cycle(1'b1, d, acc);
            tries++;
        end
        if (!acc) check("push_timeout", 32'(tries), 32'(0));
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            idle(1);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'(0));
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        up_vld = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) occ[i] = 1'b0;
        m_wr = 0;
        exp_strobe = '0;
        exp_err = 1'b0;
        check("rst_up_rdy", 32'(up_rdy), 32'(1));
        check("rst_unit_vld", 32'(unit_vld), 32'(0));
        check("rst_unit_data", 32'(unit_data), 32'(0));
        check("rst_down_vld", 32'(down_vld), 32'(0));
        check("rst_down_data", 32'(down_data), 32'(0));
        check("rst_err", 32'(err), 32'(0));
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3, input int d4);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3; dly[4] = d4;
    endtask

    task automatic check_burst(input string name, input int n);
        check({name, "_count"}, 32'(ph_cnt), 32'(n));
        check({name, "_span"}, 32'(ph_last - ph_first), 32'(n - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Back-to-back, all delays 1: strobes walk units 0..4, results in order.
        set_dly(1, 1, 1, 1, 1);
        ph_cnt = 0;
        for (int i = 1; i <= 5; i++) push(W'(i));
        wait_empty();
        check_burst("burst_d1", 5);

        // Unit 0 slowest: nothing leaves until it completes, then 5 in a row.
        set_dly(5, 1, 1, 1, 1);
        ph_cnt = 0;
        for (int i = 0; i < 5; i++) push(W'(16'hA0 + i));
        wait_empty();
        check_burst("head_blocked", 5);

        // Units 0,1,2 complete in the same cycle.
        set_dly(3, 2, 1, 1, 1);
        ph_cnt = 0;
        for (int i = 0; i < 3; i++) push(W'(16'hC0 + i));
        wait_empty();
        check_burst("simul_done", 3);

        // Bring the write pointer back to unit 0, then overfill with max delays.
        set_dly(1, 1, 1, 1, 1);
        push(16'h00F3);
        push(16'h00F4);
        wait_empty();
        set_dly(5, 5, 5, 5, 5);
        for (int i = 0; i < 7; i++) push(W'(16'hB0 + i));
        wait_empty();

        // Random traffic with random per-item delays.
        rand_dly = 1'b1;
        for (int i = 0; i < 150; i++) begin
            bit acc;
            drive_cycle($urandom_range(0, 3) != 0, W'($urandom), acc);
        end
        wait_empty();
        rand_dly = 1'b0;

        // Spurious completion on idle unit 2: sticky err, no output.
        @(negedge clk);
        #1;
        inj = 5'b00100;
        @(negedge clk);
        #1;
        inj = '0;
        exp_err = 1'b1;
        idle(6);

        // Reset with three items in flight drops them all.
        set_dly(5, 5, 5, 5, 5);
        for (int i = 0; i < 3; i++) push(W'(16'h0E0 + i));
        do_reset();
        set_dly(1, 1, 1, 1, 1);
        ph_cnt = 0;
        push(16'h0055);
        wait_empty();
        idle(8);
        check_burst("after_rst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
